modboard_link_mux: RTL and testbench

- Clocked successor to the modboard CPLD glue logic.
- Routes the single FTDI UART and DTR line to one of NCH target boards.
- Turns DTR assertion into a timed, de-bounced reset pulse on the selected board.
- Drives per-board activity LEDs and a free-running heartbeat.

---
 rtl/modboard_link_mux_if.sv | 25 ++
 rtl/modboard_link_mux.sv | 156 +++++++++++++++
 tb/tb_modboard_link_mux.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/modboard_link_mux_if.sv
// Board-link bundle for modboard_link_mux: FTDI serial/DTR, board select and
// the per-board serial, reset, LED lines plus the heartbeat nibble.
interface modboard_link_mux_if #(
    parameter int NCH   = 4,
    parameter int SEL_W = 2
);
    logic             ftdi_dtr;
    logic             ftdi_rxd;
    logic             ftdi_txd;
    logic [SEL_W-1:0] sel;
    logic [NCH-1:0]   tgt_d0;
    logic [NCH-1:0]   tgt_d1;
    logic [NCH-1:0]   tgt_rst_n;
    logic [NCH-1:0]   tgt_led;
    logic [3:0]       hb;

    modport master (
        output ftdi_dtr, ftdi_rxd, sel, tgt_d1,
        input  ftdi_txd, tgt_d0, tgt_rst_n, tgt_led, hb
    );
    modport slave (
        input  ftdi_dtr, ftdi_rxd, sel, tgt_d1,
        output ftdi_txd, tgt_d0, tgt_rst_n, tgt_led, hb
    );
endinterface

// File: rtl/modboard_link_mux.sv
// Routes one FTDI UART + DTR to one of NCH boards, turning DTR falls into timed reset pulses.
// Define MODBOARD_RST_ALL_EN to pulse every board's reset (and light every LED) instead of the selected one.
module modboard_link_mux #(
    parameter int NCH      = 4,
    parameter int SEL_W    = 2,
    parameter int RST_CYC  = 16,
    parameter int HOLD_CYC = 64,
    parameter int IDLE_CYC = 8,
    parameter int ACT_CYC  = 32,
    parameter int HB_W     = 14
) (
    input  logic               pG0,
    input  logic               pRST,
    modboard_link_mux_if.slave lnk
);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IDL_W = (IDLE_CYC < 1) ? 1 : $clog2(IDLE_CYC + 1);
    localparam int ACT_W = (ACT_CYC < 1) ? 1 : $clog2(ACT_CYC + 1);
    localparam int RMAX  = (RST_CYC > HOLD_CYC) ? RST_CYC : HOLD_CYC;
    localparam int CTR_W = $clog2(RMAX + 1);
    localparam logic [IDL_W-1:0] IDLE_MAX = IDL_W'(IDLE_CYC);
    localparam logic [ACT_W-1:0] ACT_MAX  = ACT_W'(ACT_CYC);
    localparam logic [SEL_W:0]   NCH_C    = (SEL_W + 1)'(NCH);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_e;

    logic           dtr_s1_q, dtr_s2_q, dtr_prev_q;
    logic           rxd_s1_q, rxd_s2_q;
    logic [NCH-1:0] d1_s1_q, d1_s2_q;

    // Synchronisers idle high so reset release never looks like UART or DTR activity.
    always_ff @(posedge pG0 or negedge pRST) begin
        if (!pRST) begin
            dtr_s1_q   <= 1'b1;
            dtr_s2_q   <= 1'b1;
            dtr_prev_q <= 1'b1;
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            d1_s1_q    <= '1;
            d1_s2_q    <= '1;
        end else begin
            dtr_s1_q   <= lnk.ftdi_dtr;
            dtr_s2_q   <= dtr_s1_q;
            dtr_prev_q <= dtr_s2_q;
            rxd_s1_q   <= lnk.ftdi_rxd;
            rxd_s2_q   <= rxd_s1_q;
            d1_s1_q    <= lnk.tgt_d1;
            d1_s2_q    <= d1_s1_q;
        end
    end

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] sel_idx;
    logic [IDL_W-1:0] idle_ctr_q, idle_ctr_d;
    logic [ACT_W-1:0] act_ctr_q, act_ctr_d;
    logic [HB_W-1:0]  hb_ctr_q, hb_ctr_d;
    logic [NCH-1:0]   tgt_d0_q, tgt_d0_d, led_q, led_d;
    logic             ftdi_txd_q, ftdi_txd_d;
    logic             line_idle, dtr_fall;
    state_e           state_q;
    logic [CTR_W-1:0] rst_ctr_q;
    logic [NCH-1:0]   rst_n_q;

    assign sel_idx = IDX_W'(sel_q);

    always_comb begin
        line_idle  = rxd_s2_q & d1_s2_q[sel_idx];
        dtr_fall   = dtr_prev_q & ~dtr_s2_q;
        idle_ctr_d = idle_ctr_q;
        if (!line_idle)
            idle_ctr_d = '0;
        else if (idle_ctr_q != IDLE_MAX)
            idle_ctr_d = idle_ctr_q + 1'b1;
        // Switching only after a quiet line keeps a byte from being split across boards.
        sel_d = sel_q;
        if (idle_ctr_q == IDLE_MAX && state_q == IDLE && ({1'b0, lnk.sel} < NCH_C))
            sel_d = lnk.sel;
        act_ctr_d = act_ctr_q;
        if (!line_idle)
            act_ctr_d = ACT_MAX;
        else if (act_ctr_q != '0)
            act_ctr_d = act_ctr_q - 1'b1;
        hb_ctr_d            = hb_ctr_q + 1'b1;
        tgt_d0_d            = '1;
        tgt_d0_d[sel_idx]   = rxd_s2_q;
        ftdi_txd_d          = d1_s2_q[sel_idx];
        led_d               = '0;
        led_d[sel_idx]      = (act_ctr_q == '0) | hb_ctr_q[HB_W-4];
    end

    always_ff @(posedge pG0 or negedge pRST) begin
        if (!pRST) begin
            sel_q      <= '0;
            idle_ctr_q <= '0;
            act_ctr_q  <= '0;
            hb_ctr_q   <= '0;
            tgt_d0_q   <= '1;
            ftdi_txd_q <= 1'b1;
            led_q      <= '0;
        end else begin
            sel_q      <= sel_d;
            idle_ctr_q <= idle_ctr_d;
            act_ctr_q  <= act_ctr_d;
            hb_ctr_q   <= hb_ctr_d;
            tgt_d0_q   <= tgt_d0_d;
            ftdi_txd_q <= ftdi_txd_d;
            led_q      <= led_d;
        end
    end

    // DTR edges outside IDLE are dropped: dtr_prev_q keeps tracking, so nothing queues.
    always_ff @(posedge pG0 or negedge pRST) begin
        if (!pRST) begin
            state_q   <= IDLE;
            rst_ctr_q <= '0;
            rst_n_q   <= '1;
        end else begin
            case (state_q)
                IDLE: if (dtr_fall) begin
                    state_q   <= PULSE;
                    rst_ctr_q <= '0;
`ifdef MODBOARD_RST_ALL_EN
                    rst_n_q   <= '0;
`else
                    rst_n_q   <= ~(NCH'(1) << sel_idx);
`endif
                end
                PULSE: if (rst_ctr_q == CTR_W'(RST_CYC - 1)) begin
                    state_q   <= HOLD;
                    rst_ctr_q <= '0;
                    rst_n_q   <= '1;
                end else begin
                    rst_ctr_q <= rst_ctr_q + 1'b1;
                end
                HOLD: if (rst_ctr_q == CTR_W'(HOLD_CYC - 1)) begin
                    state_q   <= IDLE;
                    rst_ctr_q <= '0;
                end else begin
                    rst_ctr_q <= rst_ctr_q + 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    rst_ctr_q <= '0;
                    rst_n_q   <= '1;
                end
            endcase
        end
    end

    assign lnk.tgt_d0    = tgt_d0_q;
    assign lnk.ftdi_txd  = ftdi_txd_q;
    assign lnk.tgt_rst_n = rst_n_q;
    // A board held in reset shows a solid LED; the reset mask is already aligned to the pulse.
    assign lnk.tgt_led   = led_q | ~rst_n_q;
    assign lnk.hb        = hb_ctr_q[HB_W-1 -: 4];
endmodule

// File: tb/tb_modboard_link_mux.sv
// Directed bench for modboard_link_mux: a history-window model is compared every cycle,
// plus literal expectations at the key points of each scenario.
module tb_modboard_link_mux;
    localparam int NCH = 4, SEL_W = 3, RST_CYC = 16, HOLD_CYC = 64;
    localparam int IDLE_CYC = 8, ACT_CYC = 32, HB_W = 14, HMAX = 4096;
`ifdef MODBOARD_RST_ALL_EN
    localparam logic [3:0] PULSE_RST = 4'b0000, PULSE_LED = 4'b1111;
`else
    localparam logic [3:0] PULSE_RST = 4'b0111, PULSE_LED = 4'b1000;
`endif

    logic pG0 = 1'b0;
    logic pRST = 1'b1;
    modboard_link_mux_if #(.NCH(NCH), .SEL_W(SEL_W)) lnk ();

    modboard_link_mux #(
        .NCH(NCH), .SEL_W(SEL_W), .RST_CYC(RST_CYC), .HOLD_CYC(HOLD_CYC),
        .IDLE_CYC(IDLE_CYC), .ACT_CYC(ACT_CYC), .HB_W(HB_W)
    ) dut (.pG0(pG0), .pRST(pRST), .lnk(lnk));

    always #5 pG0 = ~pG0;

    int n_chk = 0, n_err = 0;
    bit done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pin histories per clock edge; outputs derived from delays and time windows.
    logic           rx_h[HMAX], dt_h[HMAX], l_h[HMAX];
    logic [NCH-1:0] d1_h[HMAX];
    int             k = 0, m_sel = 0, p_start = 0, p_sel = 0;
    bit             p_have = 0;
    logic [HB_W-1:0] hbcnt = '0;
    logic [NCH-1:0] e_d0 = '1, e_rst = '1, e_led = '0;
    logic           e_txd = 1'b1;
    logic [3:0]     e_hb = '0;

    function automatic logic hrx(int j); return (j >= 1) ? rx_h[j] : 1'b1; endfunction
    function automatic logic hdt(int j); return (j >= 1) ? dt_h[j] : 1'b1; endfunction
    function automatic logic [NCH-1:0] hd1(int j); return (j >= 1) ? d1_h[j] : '1; endfunction

    task automatic mreset();
        k = 0; m_sel = 0; p_have = 0; hbcnt = '0;
        e_d0 = '1; e_rst = '1; e_led = '0; e_txd = 1'b1; e_hb = '0;
    endtask

    task automatic mstep();
        logic rx2, fall, idle_st, idle_ok, act_z, hbit;
        logic [NCH-1:0] d12, norm, pmask;
        k++;
        if (k >= HMAX) begin
            $display("FAIL model_depth: edge %0d beyond history %0d", k, HMAX);
            $fatal(1);
        end
        rx_h[k] = lnk.ftdi_rxd; dt_h[k] = lnk.ftdi_dtr; d1_h[k] = lnk.tgt_d1;
        rx2 = hrx(k - 2);
        d12 = hd1(k - 2);
        l_h[k] = rx2 & d12[m_sel];
        fall = hdt(k - 3) & ~hdt(k - 2);
        idle_st = !p_have || (k > p_start + RST_CYC + HOLD_CYC);
        idle_ok = (k - 1 >= IDLE_CYC);
        for (int j = k - IDLE_CYC; j <= k - 1; j++) if (j >= 1 && !l_h[j]) idle_ok = 1'b0;
        act_z = 1'b1;
        for (int j = k - ACT_CYC; j <= k - 1; j++) if (j >= 1 && !l_h[j]) act_z = 1'b0;
        hbit = hbcnt[HB_W-4];
        e_d0 = '1; e_d0[m_sel] = rx2;
        e_txd = d12[m_sel];
        norm = '0; norm[m_sel] = act_z | hbit;
        if (idle_st && fall) begin p_have = 1; p_start = k; p_sel = m_sel; end
        if (idle_st && idle_ok && int'(lnk.sel) < NCH) m_sel = int'(lnk.sel);
        hbcnt = hbcnt + 1'b1;
        pmask = '0;
        if (p_have && k >= p_start && k < p_start + RST_CYC) begin
`ifdef MODBOARD_RST_ALL_EN
            pmask = '1;
`else
            pmask[p_sel] = 1'b1;
`endif
        end
        e_rst = ~pmask;
        e_led = norm | pmask;
        e_hb = hbcnt[HB_W-1 -: 4];
    endtask

    initial begin
        forever begin
            @(posedge pG0 or negedge pRST);
            if (!pRST) mreset(); else mstep();
        end
    end

    initial begin
        @(posedge pG0);
        forever begin
            @(negedge pG0);
            if (!done) begin
                chk("cyc_tgt_rst_n", lnk.tgt_rst_n, e_rst);
                chk("cyc_tgt_d0", lnk.tgt_d0, e_d0);
                chk("cyc_ftdi_txd", lnk.ftdi_txd, e_txd);
                chk("cyc_tgt_led", lnk.tgt_led, e_led);
                chk("cyc_hb", lnk.hb, e_hb);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pG0);
        #1;
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        repeat (n) begin
            tick(1);
            if (lnk.tgt_rst_n !== 4'hF) lows++;
        end
    endtask

    int lows;

    initial begin
        lnk.ftdi_dtr = 1'b1; lnk.ftdi_rxd = 1'b1; lnk.sel = '0; lnk.tgt_d1 = '1;
        #1 pRST = 1'b0;
        repeat (5) begin
            @(posedge pG0); #1;
            lnk.ftdi_dtr = 1'($urandom_range(0, 1));
            lnk.ftdi_rxd = 1'($urandom_range(0, 1));
            lnk.sel      = 3'($urandom_range(0, 7));
            lnk.tgt_d1   = 4'($urandom_range(0, 15));
        end
        chk("reset_rst_n", lnk.tgt_rst_n, 4'hF);
        chk("reset_d0", lnk.tgt_d0, 4'hF);
        chk("reset_txd", lnk.ftdi_txd, 1'b1);
        chk("reset_hb", lnk.hb, 4'h0);
        chk("reset_led", lnk.tgt_led, 4'h0);
        lnk.ftdi_dtr = 1'b1; lnk.ftdi_rxd = 1'b1; lnk.sel = '0; lnk.tgt_d1 = '1;
        pRST = 1'b1;

        // Heartbeat: bit HB_W-4 first sets on count 1024.
        tick(1023); chk("hb_1023", lnk.hb, 4'h0);
        tick(1);    chk("hb_1024", lnk.hb, 4'h1);

        // Routing to board 2 with 3-cycle latency both ways.
        lnk.sel = 3'd2; tick(2);
        lnk.ftdi_rxd = 1'b0;
        tick(2); chk("route_lat2", lnk.tgt_d0, 4'hF);
        tick(1); chk("route_rxd0", lnk.tgt_d0, 4'b1011);
        lnk.ftdi_rxd = 1'b1;
        tick(3); chk("route_rxd1", lnk.tgt_d0, 4'hF);
        lnk.tgt_d1 = 4'b1011; tick(3); chk("route_txd0", lnk.ftdi_txd, 1'b0);
        lnk.tgt_d1 = 4'hF;    tick(3); chk("route_txd1", lnk.ftdi_txd, 1'b1);
        lnk.tgt_d1 = 4'b1101; tick(3); chk("route_unsel", lnk.ftdi_txd, 1'b1);
        lnk.tgt_d1 = 4'hF;

        // Deferred select while rxd is busy.
        tick(12);
        lnk.ftdi_rxd = 1'b0; tick(4);
        lnk.sel = 3'd1;
        for (int i = 0; i < 4; i++) begin
            lnk.ftdi_rxd = 1'b1; tick(4);
            lnk.ftdi_rxd = 1'b0; tick(3);
            chk("defer_still2", lnk.tgt_d0, 4'b1011);
            tick(1);
        end
        lnk.ftdi_rxd = 1'b1; tick(12);
        lnk.ftdi_rxd = 1'b0; tick(3); chk("defer_took1", lnk.tgt_d0, 4'b1101);
        lnk.ftdi_rxd = 1'b1;
        lnk.sel = 3'd5; tick(20);
        lnk.ftdi_rxd = 1'b0; tick(3); chk("sel_oob_ignored", lnk.tgt_d0, 4'b1101);
        lnk.ftdi_rxd = 1'b1;

        // Reset pulse on board 3.
        lnk.sel = 3'd3; tick(12);
        lnk.ftdi_dtr = 1'b0;
        tick(2); chk("pulse_lat2", lnk.tgt_rst_n, 4'hF);
        tick(1); chk("pulse_start", lnk.tgt_rst_n, PULSE_RST);
        chk("pulse_led", lnk.tgt_led, PULSE_LED);
        count_low(20, lows); chk("pulse_len", lows + 1, 16);

        // Holdoff: edge in HOLD ignored, held-low DTR no retrigger, later edge pulses.
        tick(6);
        lnk.ftdi_dtr = 1'b1; tick(2);
        lnk.ftdi_dtr = 1'b0;
        count_low(50, lows); chk("hold_edge_ignored", lows, 0);
        count_low(8, lows);  chk("held_low_no_retrig", lows, 0);
        lnk.ftdi_dtr = 1'b1; tick(4);
        lnk.ftdi_dtr = 1'b0;
        count_low(25, lows); chk("second_pulse_len", lows, 16);

        // Mid-pulse reset.
        lnk.ftdi_dtr = 1'b1; tick(100);
        lnk.ftdi_dtr = 1'b0; tick(3); tick(4);
        chk("mid_pulse_low", lnk.tgt_rst_n, PULSE_RST);
        pRST = 1'b0; lnk.ftdi_dtr = 1'b1;
        #1;
        chk("mid_async_rst_n", lnk.tgt_rst_n, 4'hF);
        chk("mid_async_led", lnk.tgt_led, 4'h0);
        tick(2);
        pRST = 1'b1;
        count_low(40, lows); chk("after_rst_no_pulse", lows, 0);

        tick(1);
        done = 1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
